// File: rtl/frame_cmd_pkg.sv
// Shared definitions for the frame command sequencer.
// Command word layout, info codes and FSM state encoding.
package frame_cmd_pkg;

    localparam int CMD_W     = 32;
    localparam int ID_LSB    = 26;
    localparam int CHILD_LSB = 21;
    localparam int INFO_LSB  = 17;
    localparam int TYPE_LSB  = 14;
    localparam int BUF_BIT   = 13;
    localparam int MSG_LSB   = 0;

    localparam logic [3:0] INFO_UPDATE = 4'h1;
    localparam logic [3:0] INFO_SWAP   = 4'hF;
    localparam logic [3:0] INFO_NOP    = 4'h0;

    localparam logic [CMD_W-1:0] CMD_IDLE = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VB,
        S_SWAP
    } state_t;

    // Swap broadcast aimed at the current back buffer.
    function automatic logic [CMD_W-1:0] swap_word(input logic front);
        logic [CMD_W-1:0] w;
        w = CMD_IDLE;
        w[INFO_LSB +: 4] = INFO_SWAP;
        w[BUF_BIT] = ~front;
        return w;
    endfunction

    // Redirect a queued command to the current back buffer.
    function automatic logic [CMD_W-1:0] steer(
        input logic [CMD_W-1:0] cmd,
        input logic             front
    );
        logic [CMD_W-1:0] w;
        w = cmd;
        w[BUF_BIT] = ~front;
        return w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for queued commands.
// Head entry is visible on rd_data whenever empty is low.
module cmd_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 33,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_n;
    logic             do_push;
    logic             do_pop;

    // A push on a full FIFO is accepted only when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_n = count - 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
            full  <= (count_n == (AW+1)'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/frame_cmd_sequencer.sv
// Sprite pipeline front end: queues HPS commands and replays them
// onto the component bus, holding buffer swaps for vertical blanking.
module frame_cmd_sequencer
    import frame_cmd_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int VBLANK_START = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        front_buf
);

    localparam int AW = $clog2(DEPTH);

    state_t      state;
    logic        blank_used;
    logic        overflow;
    logic [AW:0] marker_cnt;

    logic        wr_en;
    logic        push;
    logic        is_commit;
    logic [32:0] push_data;
    logic        pop;
    logic [32:0] head;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_ok;
    logic        in_vblank;
    logic        swap_pending;
    logic [6:0]  fill;

    assign wr_en     = chipselect && write;
    assign is_commit = (address == 2'd1);
    assign push      = wr_en && (address == 2'd0 || is_commit);
    assign push_data = is_commit ? {1'b1, CMD_IDLE} : {1'b0, writedata};
    assign pop       = !fifo_empty && (state != S_WAIT_VB);
    assign push_ok   = push && (!fifo_full || pop);
    assign in_vblank = (vcount >= 10'(VBLANK_START));
    assign fill      = 7'(fifo_count);

    assign swap_pending = (marker_cnt != '0) || (state == S_WAIT_VB);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (push_data),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Status word reflects pre-write state of the current cycle.
    always_comb begin
        readdata = '0;
        if (chipselect && read) begin
            readdata[6:0] = fill;
            readdata[8]   = front_buf;
            readdata[9]   = swap_pending;
            readdata[10]  = overflow;
        end
    end

    // Sticky overflow: set on a dropped push, cleared by address 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (wr_en && address == 2'd2) begin
            overflow <= 1'b0;
        end
    end

    // Count of commit markers still sitting in the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            marker_cnt <= '0;
        end else begin
            case ({push_ok && is_commit, pop && head[32]})
                2'b10:   marker_cnt <= marker_cnt + 1'b1;
                2'b01:   marker_cnt <= marker_cnt - 1'b1;
                default: marker_cnt <= marker_cnt;
            endcase
        end
    end

    // Issue FSM: one entry per cycle, swaps gated to one per blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_out    <= CMD_IDLE;
            front_buf  <= 1'b0;
            blank_used <= 1'b0;
        end else begin
            case (state)
                S_WAIT_VB: begin
                    if (in_vblank && !blank_used) begin
                        state      <= S_SWAP;
                        cmd_out    <= swap_word(front_buf);
                        front_buf  <= ~front_buf;
                        blank_used <= 1'b1;
                    end else begin
                        cmd_out <= CMD_IDLE;
                        if (!in_vblank) begin
                            blank_used <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!in_vblank) begin
                        blank_used <= 1'b0;
                    end
                    if (pop && head[32]) begin
                        state   <= S_WAIT_VB;
                        cmd_out <= CMD_IDLE;
                    end else if (pop) begin
                        state   <= S_ISSUE;
                        cmd_out <= steer(head[31:0], front_buf);
                    end else begin
                        state   <= S_IDLE;
                        cmd_out <= CMD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_cmd_sequencer.sv
// Directed self-checking bench for frame_cmd_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_frame_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        front_buf;

    int pass_cnt = 0;
    int total_cnt = 0;

    frame_cmd_sequencer #(
        .DEPTH        (64),
        .VBLANK_START (480)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .vcount     (vcount),
        .cmd_out    (cmd_out),
        .front_buf  (front_buf)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic rd_status(output logic [31:0] s);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 2'd3;
        #1;
        s = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset      = 1'b1;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 2'd0;
        writedata  = 32'h0;
        vcount     = 10'd100;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL reset_cmd: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (front_buf !== 1'b0)
            $display("FAIL reset_front: got %b expected 0", front_buf);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0)
            $display("FAIL reset_status: got %h expected %h", s, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_single_cmd();
        vcount = 10'd100;
        wr(2'd0, 32'h2820_4001);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL single_early: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h2820_6001)
            $display("FAIL single_issue: got %h expected %h", cmd_out, 32'h2820_6001);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL single_after: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        vcount = 10'd200;
        wr(2'd0, 32'h0C22_0005);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL b2b_pre: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        wr(2'd0, 32'h1043_2007);
        total_cnt++;
        if (cmd_out !== 32'h0C22_2005)
            $display("FAIL b2b_a: got %h expected %h", cmd_out, 32'h0C22_2005);
        else pass_cnt++;
        wr(2'd0, 32'h1464_0009);
        total_cnt++;
        if (cmd_out !== 32'h1043_2007)
            $display("FAIL b2b_b: got %h expected %h", cmd_out, 32'h1043_2007);
        else pass_cnt++;
        wr(2'd1, 32'h0);
        total_cnt++;
        if (cmd_out !== 32'h1464_2009)
            $display("FAIL b2b_c: got %h expected %h", cmd_out, 32'h1464_2009);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL b2b_marker: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0200)
            $display("FAIL b2b_pending: got %h expected %h", s, 32'h200);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0 || front_buf !== 1'b0)
            $display("FAIL b2b_hold: got %h/%b expected 0/0", cmd_out, front_buf);
        else pass_cnt++;
        vcount = 10'd480;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h001E_2000)
            $display("FAIL b2b_swap: got %h expected %h", cmd_out, 32'h001E_2000);
        else pass_cnt++;
        total_cnt++;
        if (front_buf !== 1'b1)
            $display("FAIL b2b_front: got %b expected 1", front_buf);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0100)
            $display("FAIL b2b_status: got %h expected %h", s, 32'h100);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL b2b_swap_once: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_one_swap_per_frame();
        logic [31:0] s;
        int nz;
        vcount = 10'd0;
        @(negedge clk);
        vcount = 10'd490;
        wr(2'd1, 32'h0);
        wr(2'd1, 32'h0);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL osf_wait: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h001E_0000 || front_buf !== 1'b0)
            $display("FAIL osf_swap1: got %h/%b expected %h/0",
                     cmd_out, front_buf, 32'h001E_0000);
        else pass_cnt++;
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_out !== 32'h0) nz++;
        end
        total_cnt++;
        if (nz !== 0)
            $display("FAIL osf_no_second: got %0d busy cycles expected 0", nz);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0200)
            $display("FAIL osf_pending: got %h expected %h", s, 32'h200);
        else pass_cnt++;
        vcount = 10'd0;
        @(negedge clk);
        vcount = 10'd480;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h001E_2000 || front_buf !== 1'b1)
            $display("FAIL osf_swap2: got %h/%b expected %h/1",
                     cmd_out, front_buf, 32'h001E_2000);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL osf_after: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        vcount = 10'd100;
        wr(2'd1, 32'h0);
        for (int i = 0; i < 64; i++) begin
            wr(2'd0, 32'h0820_0000 | i);
        end
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0340)
            $display("FAIL ovf_full: got %h expected %h", s, 32'h340);
        else pass_cnt++;
        wr(2'd0, 32'h0820_0040);
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0740)
            $display("FAIL ovf_set: got %h expected %h", s, 32'h740);
        else pass_cnt++;
        wr(2'd2, 32'h0);
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0340)
            $display("FAIL ovf_clear: got %h expected %h", s, 32'h340);
        else pass_cnt++;
        vcount = 10'd480;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h001E_0000 || front_buf !== 1'b0)
            $display("FAIL ovf_swap: got %h/%b expected %h/0",
                     cmd_out, front_buf, 32'h001E_0000);
        else pass_cnt++;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            total_cnt++;
            if (cmd_out !== (32'h0820_2000 | i))
                $display("FAIL ovf_drain_%0d: got %h expected %h",
                         i, cmd_out, 32'h0820_2000 | i);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL ovf_dropped: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0)
            $display("FAIL ovf_empty: got %h expected %h", s, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_cmd_after_commit();
        logic [31:0] s;
        vcount = 10'd100;
        @(negedge clk);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h1C40_3FFF);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL cac_held: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0201)
            $display("FAIL cac_status: got %h expected %h", s, 32'h201);
        else pass_cnt++;
        vcount = 10'd480;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h001E_2000 || front_buf !== 1'b1)
            $display("FAIL cac_swap: got %h/%b expected %h/1",
                     cmd_out, front_buf, 32'h001E_2000);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h1C40_1FFF)
            $display("FAIL cac_cmd: got %h expected %h", cmd_out, 32'h1C40_1FFF);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_out !== 32'h0)
            $display("FAIL cac_after: got %h expected %h", cmd_out, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] s;
        int nz;
        vcount = 10'd100;
        @(negedge clk);
        wr(2'd1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 32'h0400_0001 + i);
        end
        @(negedge clk);
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0000_0305)
            $display("FAIL rst_wait_pre: got %h expected %h", s, 32'h305);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        rd_status(s);
        total_cnt++;
        if (s !== 32'h0)
            $display("FAIL rst_wait_status: got %h expected %h", s, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (cmd_out !== 32'h0 || front_buf !== 1'b0)
            $display("FAIL rst_wait_out: got %h/%b expected 0/0", cmd_out, front_buf);
        else pass_cnt++;
        reset  = 1'b0;
        vcount = 10'd480;
        nz = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmd_out !== 32'h0) nz++;
        end
        total_cnt++;
        if (nz !== 0 || front_buf !== 1'b0)
            $display("FAIL rst_wait_noswap: got %0d busy/front %b expected 0/0",
                     nz, front_buf);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_one_swap_per_frame();
        test_overflow();
        test_cmd_after_commit();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
